// File: rtl/us_ranger_pkg.sv
// us_ranger_pkg: shared constants, FSM state codes and helpers for the multi-channel ultrasonic ranger
package us_ranger_pkg;
    localparam int SCALE_SH  = 24;
    localparam int US_PER_CM = 58;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TRIG      = 3'd1;
    localparam logic [2:0] WAIT_RISE = 3'd2;
    localparam logic [2:0] MEASURE   = 3'd3;
    localparam logic [2:0] CONVERT   = 3'd4;
    localparam logic [2:0] PRESENT   = 3'd5;
    localparam logic [2:0] HOLDOFF   = 3'd6;
    function automatic int ch_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/us_ranger_multi_if.sv
// us_ranger_multi_if: result valid/ready channel (channel tag, distance, timeout flag)
//   master drives valid/ch/cm/timeout and samples ready; slave is the consumer
interface us_ranger_multi_if #(
    parameter int CH_W   = 2,
    parameter int DIST_W = 16
);
    logic              valid;
    logic              ready;
    logic [CH_W-1:0]   ch;
    logic [DIST_W-1:0] cm;
    logic              timeout;
    modport master (output valid, ch, cm, timeout, input ready);
    modport slave  (input valid, ch, cm, timeout, output ready);
endinterface

// File: rtl/us_echo_sync.sv
// us_echo_sync: W-wide two-flop synchroniser for the asynchronous echo pins
//   clk_i, rst_i : clock, async active-high reset
//   d_i          : raw pins
//   q_o          : synchronised pins, 2 clk latency
module us_echo_sync #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q, sync_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end
    assign q_o = sync_q;
endmodule

// File: rtl/us_ranger_multi.sv
// us_ranger_multi: round-robin HC-SR04 style range controller with timeout and cm conversion
//   clk_i, rst_i : clock, async active-high reset
//   enable_i     : run the measurement cycle
//   echo_i       : raw echo pins, one per sensor
//   trig_o       : trigger pins, one-hot or zero
//   busy_o       : FSM is not idle
//   dist_if      : result handshake (valid/ready, ch, cm, timeout)
module us_ranger_multi
    import us_ranger_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int NUM_CH     = 4,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int PERIOD_US  = 60000,
    parameter int DIST_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [NUM_CH-1:0] echo_i,
    output logic [NUM_CH-1:0] trig_o,
    output logic              busy_o,
    us_ranger_multi_if.master dist_if
);
    localparam int CH_W     = ch_width(NUM_CH);
    localparam int CYC_US   = CLK_HZ / 1_000_000;
    localparam int CYC_CM   = US_PER_CM * CYC_US;
    localparam int TRIG_CYC = TRIG_US * CYC_US;
    localparam int TO_CYC   = TIMEOUT_US * CYC_US;
    localparam int PER_CYC  = PERIOD_US * CYC_US;
    localparam int PW       = $clog2(TRIG_CYC + 1);
    localparam int WW       = $clog2(TO_CYC + 1);
    localparam int RW       = $clog2(PER_CYC + 1);
    localparam logic [PW-1:0] TRIG_LAST = PW'(TRIG_CYC - 1);
    localparam logic [WW-1:0] TO_LAST   = WW'(TO_CYC - 1);
    localparam logic [RW-1:0] PER_LAST  = RW'(PER_CYC - 1);
    localparam logic [47:0]   K         = 48'(((1 << SCALE_SH) + CYC_CM - 1) / CYC_CM);
    localparam logic [47:0]   CM_MAX    = 48'((1 << DIST_W) - 2);

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PW-1:0]     pulse_q, pulse_d;
    logic [RW-1:0]     period_q, period_d;
    logic [WW-1:0]     width_q, width_d;
    logic [DIST_W-1:0] cm_q, cm_d;
    logic              to_q, to_d;
    logic [NUM_CH-1:0] echo_s, sel;
    logic              echo_hit;
    logic [47:0]       cm_raw;
    logic [DIST_W-1:0] cm_sat;

    us_echo_sync #(.W(NUM_CH)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (echo_i),
        .q_o   (echo_s)
    );

    assign sel      = NUM_CH'(1) << ch_q;
    assign echo_hit = |(echo_s & sel);
    assign cm_raw   = (48'(width_q) * K) >> SCALE_SH;
    // all-ones is reserved for timeouts, so real distances stop one below it
    assign cm_sat   = cm_raw > CM_MAX ? DIST_W'(CM_MAX) : cm_raw[DIST_W-1:0];

    // trig decodes straight from state so an async reset drops it immediately
    assign trig_o          = state_q == TRIG ? sel : '0;
    assign busy_o          = state_q != IDLE;
    assign dist_if.valid   = state_q == PRESENT;
    assign dist_if.ch      = ch_q;
    assign dist_if.cm      = cm_q;
    assign dist_if.timeout = to_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cm_d     = cm_q;
        to_d     = to_q;
        pulse_d  = state_q == TRIG ? pulse_q + 1'b1 : '0;
        // period counter saturates; it is restarted on every trigger start
        period_d = period_q == PER_LAST ? period_q : period_q + 1'b1;
        // one counter serves as rise timeout in WAIT_RISE and pulse width in MEASURE
        width_d  = (state_q == WAIT_RISE || state_q == MEASURE) ? width_q + 1'b1 : width_q;
        case (state_q)
            IDLE: if (enable_i) begin
                state_d  = TRIG;
                period_d = '0;
            end
            TRIG: if (pulse_q == TRIG_LAST) begin
                state_d = WAIT_RISE;
                width_d = '0;
            end
            WAIT_RISE: if (echo_hit) begin
                state_d = MEASURE;
                width_d = '0;
            end else if (width_q == TO_LAST) begin
                state_d = PRESENT;
                cm_d    = '1;
                to_d    = 1'b1;
            end
            MEASURE: if (!echo_hit) begin
                state_d = CONVERT;
                width_d = width_q;
            end else if (width_q == TO_LAST) begin
                state_d = PRESENT;
                cm_d    = '1;
                to_d    = 1'b1;
            end
            CONVERT: begin
                state_d = PRESENT;
                cm_d    = cm_sat;
                to_d    = 1'b0;
            end
            PRESENT: if (dist_if.ready) state_d = HOLDOFF;
            HOLDOFF: if (period_q == PER_LAST) begin
                ch_d     = ch_q == CH_W'(NUM_CH - 1) ? '0 : ch_q + 1'b1;
                state_d  = enable_i ? TRIG : IDLE;
                period_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            pulse_q  <= '0;
            period_q <= '0;
            width_q  <= '0;
            cm_q     <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            pulse_q  <= pulse_d;
            period_q <= period_d;
            width_q  <= width_d;
            cm_q     <= cm_d;
            to_q     <= to_d;
        end
    end
endmodule

// File: tb/tb_us_ranger_multi.sv
// tb_us_ranger_multi: randomized self-checking bench for us_ranger_multi against a behavioural model
module tb_us_ranger_multi;
    localparam int     TRIG_CYC = 10;
    localparam int     TO       = 1200;
    localparam int     PER      = 2000;
    localparam longint K        = ((64'd1 << 24) + 57) / 58;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] echo = 4'h0;
    logic [3:0] trig;
    logic       busy;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         exp_ch = 0;
    int         exp_start = 0;
    bit         gap_known = 1'b0;

    us_ranger_multi_if #(.CH_W(2), .DIST_W(4)) dist_if ();

    us_ranger_multi #(
        .CLK_HZ(1_000_000), .NUM_CH(4), .TRIG_US(10),
        .TIMEOUT_US(1200), .PERIOD_US(2000), .DIST_W(4)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .echo_i   (echo),
        .trig_o   (trig),
        .busy_o   (busy),
        .dist_if  (dist_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // {timeout, cm}: echo held len clocks; the rising clock itself is not counted
    function automatic logic [4:0] model(input int len, input bit stuck);
        longint c;
        if (stuck || len == 0 || len - 1 >= TO) return 5'h1F;
        c = (longint'(len - 1) * K) >>> 24;
        return {1'b0, c > 14 ? 4'd14 : 4'(c)};
    endfunction

    task automatic run_meas(input int d, input int len, input int rd, input bit stuck, input bit drop_en);
        int         ch, ts, hs, tl, i;
        bit         got, stable;
        logic [3:0] mask, cap_cm;
        logic [1:0] cap_ch;
        logic       cap_to;
        logic [4:0] exp;
        ch   = exp_ch;
        mask = 4'(1 << ch);
        i = 0;
        while (trig === 4'h0 && i < 6000) begin @(negedge clk); i++; end
        ts = cyc;
        check("trig_sel", trig, mask);
        if (gap_known) check("trig_start", ts, exp_start);
        if (drop_en) enable = 1'b0;
        if (stuck) echo = mask;
        tl = 0;
        while (trig === mask && tl < 100) begin @(negedge clk); tl++; end
        check("trig_len", tl, TRIG_CYC);
        check("trig_off", trig, 0);
        got = 1'b0;
        i = 0;
        while ((!got || i < d + len) && i < 5000) begin
            echo = ((stuck || (i >= d && i < d + len)) ? mask : 4'h0) | (4'($urandom) & ~mask);
            @(negedge clk);
            i++;
            if (!got && dist_if.valid === 1'b1) begin
                got    = 1'b1;
                cap_cm = dist_if.cm;
                cap_ch = dist_if.ch;
                cap_to = dist_if.timeout;
            end
        end
        echo = 4'h0;
        exp  = model(len, stuck);
        check("result_seen", got, 1);
        check("dist_ch", cap_ch, ch);
        check("dist_cm", cap_cm, exp[3:0]);
        check("dist_timeout", cap_to, exp[4]);
        stable = 1'b1;
        repeat (rd) begin
            @(negedge clk);
            if (dist_if.valid !== 1'b1 || dist_if.cm !== cap_cm || dist_if.ch !== cap_ch ||
                dist_if.timeout !== cap_to || trig !== 4'h0) stable = 1'b0;
        end
        if (rd > 0) check("hold_stable", stable, 1);
        dist_if.ready = 1'b1;
        hs = cyc;
        @(negedge clk);
        dist_if.ready = 1'b0;
        check("valid_drop", dist_if.valid, 0);
        exp_ch    = (exp_ch + 1) % 4;
        exp_start = (ts + PER > hs + 2) ? ts + PER : hs + 2;
        gap_known = !drop_en;
    endtask

    task automatic mid_reset(input bit in_meas);
        int i;
        i = 0;
        while (trig === 4'h0 && i < 6000) begin @(negedge clk); i++; end
        if (in_meas) begin
            i = 0;
            while (trig !== 4'h0 && i < 100) begin @(negedge clk); i++; end
            echo = 4'(1 << exp_ch);
            repeat (30) @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_trig", trig, 0);
        check("rst_valid", dist_if.valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cm", dist_if.cm, 0);
        check("rst_ch", dist_if.ch, 0);
        @(negedge clk);
        rst       = 1'b0;
        echo      = 4'h0;
        exp_ch    = 0;
        exp_start = cyc + 1;
        gap_known = 1'b1;
    endtask

    initial begin
        bit quiet;
        dist_if.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trig0", trig, 0);
        check("rst_valid0", dist_if.valid, 0);
        check("rst_ch0", dist_if.ch, 0);
        check("rst_cm0", dist_if.cm, 0);
        check("rst_to0", dist_if.timeout, 0);
        check("rst_busy0", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy0", busy, 0);
        enable    = 1'b1;
        exp_start = cyc + 1;
        gap_known = 1'b1;
        run_meas(3, 581, 0, 0, 0);
        run_meas(0, 0, 0, 0, 0);
        run_meas(7, 300, 1000, 0, 0);
        run_meas(2, TO, 0, 0, 0);
        run_meas(4, TO + 1, 0, 0, 0);
        run_meas(0, 1300, 0, 1, 0);
        run_meas(1, 1, 3, 0, 0);
        for (int n = 0; n < 10; n++) begin
            int r, len, rd;
            r   = $urandom_range(0, 9);
            len = r < 2 ? 0 : (r < 3 ? $urandom_range(TO, TO + 100) : $urandom_range(1, 1100));
            rd  = ($urandom_range(0, 3) == 0) ? $urandom_range(500, 1500) : $urandom_range(0, 5);
            run_meas($urandom_range(0, 20), len, rd, 0, 0);
        end
        run_meas(5, 400, 0, 0, 1);
        quiet = 1'b1;
        repeat (PER + 50) begin
            @(negedge clk);
            if (trig !== 4'h0) quiet = 1'b0;
        end
        check("idle_quiet", quiet, 1);
        check("idle_busy", busy, 0);
        enable    = 1'b1;
        exp_start = cyc + 1;
        gap_known = 1'b1;
        run_meas(6, 200, 0, 0, 0);
        mid_reset(1'b0);
        run_meas(2, 150, 0, 0, 0);
        mid_reset(1'b1);
        run_meas(3, 700, 0, 0, 0);
        enable = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
